// File: rtl/axi_host_mem_responder.sv
// AXI4 slave backed by a byte-enabled RAM: INCR read/write bursts with ID echo, one burst per direction.
// Optional macro AXI_HOST_MEM_RESP_RANGE_ERR_EN: out-of-range bursts answer SLVERR instead of wrapping.
module axi_host_mem_responder #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int LEN_W      = 8,
    parameter int ID_W       = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                bcd_clk,
    input  logic                bcd_reset,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [LEN_W-1:0]    s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [LEN_W-1:0]    s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = DEPTH_LOG2;
    localparam int CNT_W  = LEN_W + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    logic [DATA_W-1:0] mem [2**IDX_W];

    logic              ar_err, aw_err;

`ifdef AXI_HOST_MEM_RESP_RANGE_ERR_EN
    localparam int SUM_W = ((IDX_W > LEN_W) ? IDX_W : LEN_W) + 1;

    function automatic logic range_err(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        logic [SUM_W-1:0] last_idx;
        last_idx = SUM_W'(addr[IDX_W+OFF_W-1:OFF_W]) + SUM_W'(len);
        return (|addr[ADDR_W-1:IDX_W+OFF_W]) || (last_idx > SUM_W'(2**IDX_W - 1));
    endfunction

    assign ar_err = range_err(s_axi_araddr, s_axi_arlen);
    assign aw_err = range_err(s_axi_awaddr, s_axi_awlen);
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    // Size fields and byte-offset bits carry no information for full-width aligned bursts.
    logic unused_bits;
    assign unused_bits = ^{s_axi_arsize, s_axi_awsize, s_axi_araddr, s_axi_awaddr};

    logic [0:0]        rd_state;
    logic [ID_W-1:0]   rd_id;
    logic              rd_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [CNT_W-1:0]  rd_left;
    logic              vld_p1;
    logic              last_p1;
    logic [DATA_W-1:0] rd_data_p1;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              fifo_wr_ptr, fifo_rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              ar_fire, r_pop, rd_issue;

    logic [1:0]        wr_state;
    logic [ID_W-1:0]   wr_id;
    logic              wr_err;
    logic [IDX_W-1:0]  wr_idx;
    logic              aw_fire, w_fire;

    assign ar_fire  = s_axi_arvalid && (rd_state == R_IDLE);
    assign r_pop    = s_axi_rvalid && s_axi_rready;
    // A read is issued only if its word is sure to find a FIFO slot one cycle later.
    assign rd_issue = (rd_state == R_BURST) && (rd_left != '0) &&
                      (((fifo_cnt + 2'(vld_p1)) < 2'd2) || r_pop);

    assign aw_fire  = s_axi_awvalid && (wr_state == W_IDLE);
    assign w_fire   = s_axi_wvalid && (wr_state == W_DATA);

    always_ff @(posedge bcd_clk) begin
        if (bcd_reset) begin
            rd_state    <= R_IDLE;
            rd_id       <= '0;
            rd_err      <= 1'b0;
            rd_left     <= '0;
            vld_p1      <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (ar_fire) begin
                rd_state <= R_BURST;
                rd_id    <= s_axi_arid;
                rd_err   <= ar_err;
                rd_left  <= CNT_W'(s_axi_arlen) + CNT_W'(1);
            end else begin
                if (r_pop && s_axi_rlast)
                    rd_state <= R_IDLE;
                if (rd_issue)
                    rd_left <= rd_left - CNT_W'(1);
            end
            vld_p1 <= rd_issue;
            if (vld_p1)
                fifo_wr_ptr <= ~fifo_wr_ptr;
            if (r_pop)
                fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(vld_p1) - 2'(r_pop);
        end
    end

    always_ff @(posedge bcd_clk) begin
        if (bcd_reset) begin
            wr_state <= W_IDLE;
            wr_id    <= '0;
            wr_err   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (aw_fire) begin
                    wr_state <= W_DATA;
                    wr_id    <= s_axi_awid;
                    wr_err   <= aw_err;
                end
                W_DATA: if (w_fire && s_axi_wlast) wr_state <= W_RESP;
                W_RESP: if (s_axi_bready) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: RAM access; a same-word write in this cycle leaves the old word on the read.
    always_ff @(posedge bcd_clk) begin
        if (w_fire && !wr_err) begin
            for (int b = 0; b < STRB_W; b++)
                if (s_axi_wstrb[b])
                    mem[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
        if (rd_issue)
            rd_data_p1 <= mem[rd_idx];
        last_p1 <= (rd_left == CNT_W'(1));
        if (ar_fire)
            rd_idx <= s_axi_araddr[IDX_W+OFF_W-1:OFF_W];
        else if (rd_issue)
            rd_idx <= rd_idx + IDX_W'(1);
        if (aw_fire)
            wr_idx <= s_axi_awaddr[IDX_W+OFF_W-1:OFF_W];
        else if (w_fire)
            wr_idx <= wr_idx + IDX_W'(1);
        // Stage p1 -> skid FIFO
        if (vld_p1) begin
            fifo_data[fifo_wr_ptr] <= rd_data_p1;
            fifo_last[fifo_wr_ptr] <= last_p1;
        end
    end

    assign s_axi_arready = (rd_state == R_IDLE);
    assign s_axi_rvalid  = (fifo_cnt != 2'd0);
    assign s_axi_rdata   = rd_err ? '0 : fifo_data[fifo_rd_ptr];
    assign s_axi_rlast   = s_axi_rvalid && fifo_last[fifo_rd_ptr];
    assign s_axi_rid     = rd_id;
    assign s_axi_rresp   = rd_err ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_awready = (wr_state == W_IDLE);
    assign s_axi_wready  = (wr_state == W_DATA);
    assign s_axi_bvalid  = (wr_state == W_RESP);
    assign s_axi_bid     = wr_id;
    assign s_axi_bresp   = wr_err ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: doc/axi_host_mem_responder.md
Name: axi_host_mem_responder

Overview:
- AXI4 memory-side responder: the slave end of the host-memory master port that the Fletcher AxiTop drives.
- Backs the port with an internal byte-enabled RAM, so kernels can be simulated and hardware-tested without the OFS host channel.
- Serves INCR read and write bursts with ID echo on R and B. This closes the ID-tag gap on the memory side.
- Read and write channels run independently; one outstanding burst per direction.

Parameters:
- ADDR_W, 64, byte-address width of ar/aw addr
- DATA_W, 512, data bus width in bits; power of two, at least 32
- LEN_W, 8, burst length field width (beats = len+1)
- ID_W, 8, transaction ID width
- DEPTH_LOG2, 10, RAM depth = 2^DEPTH_LOG2 words of DATA_W bits

Ports:
- bcd_clk  in  1  bus clock
- bcd_reset  in  1  synchronous active-high reset
- s_axi_araddr  in  ADDR_W  read byte address
- s_axi_arlen  in  LEN_W  read burst length-1
- s_axi_arsize  in  3  beat size; only log2(DATA_W/8) is supported
- s_axi_arid  in  ID_W  read ID
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_rdata  out  DATA_W
- s_axi_rresp  out  2
- s_axi_rid  out  ID_W
- s_axi_rlast  out  1
- s_axi_rvalid  out  1
- s_axi_rready  in  1
- s_axi_awaddr  in  ADDR_W
- s_axi_awlen  in  LEN_W
- s_axi_awsize  in  3
- s_axi_awid  in  ID_W
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_wdata  in  DATA_W
- s_axi_wstrb  in  DATA_W/8
- s_axi_wlast  in  1
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_bresp  out  2
- s_axi_bid  out  ID_W
- s_axi_bvalid  out  1
- s_axi_bready  in  1

Behaviour:
- Clock and reset: single clock bcd_clk; bcd_reset is synchronous, active-high.
- Reset values: arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0; rresp, bresp, rid, bid = 0.
- Reset mid-burst aborts the burst and returns both FSMs to IDLE. RAM contents are not cleared.
- Word index = addr[DEPTH_LOG2+log2(DATA_W/8)-1 : log2(DATA_W/8)]. Low byte-offset bits are ignored (aligned bursts only).
- Size: size fields are not checked; every beat is full width.
- Burst type: INCR only; the word index increments by 1 per beat and wraps modulo 2^DEPTH_LOG2.
- Read FSM:
  - R_IDLE: arready=1. An ar handshake latches the ID, word index and beat count, then moves to R_BURST.
  - R_BURST: arready=0. RAM has 1-cycle read latency, fronted by a 2-entry skid FIFO.
  - First rvalid no earlier than 2 cycles after the ar handshake.
  - With rready held high, the bus carries one beat per cycle with no bubbles.
  - rid = latched ID on every beat. rlast=1 exactly on beat len+1.
  - The rlast handshake returns the FSM to R_IDLE; arready=1 on the next cycle.
  - rdata/rvalid/rlast/rid/rresp are held stable while rvalid=1 and rready=0.
- Write FSM:
  - W_IDLE: awready=1, wready=0. An aw handshake moves to W_DATA.
  - W_DATA: wready=1. Each w handshake writes the bytes selected by wstrb at the current index; strb=0 bytes are unchanged.
  - The wlast handshake moves to W_RESP. The burst terminates on wlast only; beat-count mismatches against awlen are not flagged.
  - W_RESP: bvalid=1, bid = latched awid, bresp=OKAY. The bready handshake returns to W_IDLE.
  - W beats presented before the aw handshake are stalled (wready=0).
- Read-during-write to the same word in the same cycle returns the old data.

Optional Feature:
- Macro: AXI_HOST_MEM_RESP_RANGE_ERR_EN.
- Defined: a burst is out of range if any address bit at or above DEPTH_LOG2+log2(DATA_W/8) is set, or if start index + len exceeds 2^DEPTH_LOG2-1.
  - Out-of-range read: every beat returns rresp=SLVERR (2'b10) with rdata=0.
  - Out-of-range write: all beats are accepted but the RAM is not written; bresp=SLVERR.
- Undefined: high address bits are ignored, indices wrap, and resp is always OKAY (2'b00).

Test Plan:
- Single write then read: aw addr=0x40, len=0, id=3, data=0xA5..A5, strb all 1 -> bid=3, bresp=0; ar addr=0x40, id=7 -> one beat, rdata=0xA5..A5, rid=7, rlast=1.
- Partial strobe: write 0x11..11 to word 2, then 0xFF..FF with strb=0x1 -> read returns byte0=0xFF, other bytes 0x11.
- Read burst len=15, rready held 1 -> 16 consecutive beats with no bubbles, rlast only on beat 16; repeat with rready toggled every other cycle -> same data order, no beat lost or duplicated.
- Concurrent read and write bursts (len=7) to disjoint regions -> both complete with correct IDs and data; the write-channel handshake does not stall the read beats.
- Reset asserted on beat 5 of a len=15 read -> next cycle rvalid=0, arready=1; a new ar is then served correctly.
- With AXI_HOST_MEM_RESP_RANGE_ERR_EN: read at index 2^DEPTH_LOG2-2 with len=3 -> 4 beats, rresp=2'b10, rdata=0. Without the macro, the same read wraps to index 0 with rresp=0.
